stream_byte_packer: RTL

- Byte-to-word width upsizer sitting directly downstream of the 8-bit stream register on the byte path.
- Accepts bytes over a valid/ready handshake and packs NUM_BYTES consecutive bytes into one word, little-endian.
- Presents each word on a registered valid/ready output with a per-byte strobe.
- Sustains one byte per cycle while the consumer keeps up.

---
 rtl/stream_pkg.sv | 17 +
 rtl/fifo_v2.sv | 75 +++++++
 rtl/stream_byte_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the byte-stream packing path.
// Optional packet-boundary support in the packer is enabled by STREAM_BYTE_PACKER_LAST_EN.
package stream_pkg;

    localparam int unsigned MaxPackBytes = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [8*MaxPackBytes-1:0] data;
        logic [MaxPackBytes-1:0]   strb;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/fifo_v2.sv
// Small synchronous FIFO with optional fall-through; used as the packer's output holding stage.
// A simultaneous push and pop on a full FIFO replaces the leaving entry without a bubble.
module fifo_v2 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CNTW-1:0]       r_count;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_tm;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_unused_tm = testmode_i;
    assign w_full      = (r_count == CNTW'(DEPTH));
    assign full_o      = w_full;
    assign empty_o     = (r_count == '0) && !(FALL_THROUGH && push_i);
    assign w_pop       = pop_i && !empty_o;
    assign w_push      = push_i && (!w_full || pop_i);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == r_rd_ptr) w_rd_data = r_mem[i];
        end
        data_o = (FALL_THROUGH && (r_count == '0)) ? data_i : w_rd_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (AW'(i) == r_wr_ptr) r_mem[i] <= data_i;
                end
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/stream_byte_packer.sv
// Packs NUM_BYTES consecutive bytes little-endian into one word behind a one-entry output stage.
// Define STREAM_BYTE_PACKER_LAST_EN to add last_i/last_o and early word closing on last_i.
module stream_byte_packer
    import stream_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   testmode_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [7:0]             data_i,
`ifdef STREAM_BYTE_PACKER_LAST_EN
    input  logic                   last_i,
    output logic                   last_o,
`endif
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [8*NUM_BYTES-1:0] data_o,
    output logic [NUM_BYTES-1:0]   strb_o
);

    localparam int unsigned   CW       = cnt_width(NUM_BYTES);
    localparam int unsigned   DW       = 8*NUM_BYTES + NUM_BYTES + 1;
    localparam logic [CW-1:0] LastSlot = CW'(NUM_BYTES - 1);

    logic [8*(NUM_BYTES-1)-1:0] acc_q;
    logic [CW-1:0]              cnt_q;
    logic                       w_last_in;
    logic                       w_close;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_full;
    logic                       w_empty;
    beat_t                      w_beat_in;
    logic [DW-1:0]              w_fifo_in;
    logic [DW-1:0]              w_fifo_out;
    logic                       w_unused_pad;

`ifdef STREAM_BYTE_PACKER_LAST_EN
    assign w_last_in = last_i;
    assign last_o    = valid_o & w_fifo_out[0];
`else
    assign w_last_in = 1'b0;
`endif

    // ready_i only reaches ready_o when this byte would close a word
    assign w_close  = (cnt_q == LastSlot) || w_last_in;
    assign valid_o  = !w_empty;
    assign ready_o  = !clr_i && (!w_close || !valid_o || ready_i);
    assign w_accept = valid_i && ready_o;
    assign w_push   = w_accept && w_close;

    // Unfilled slots of acc_q are always zero, so early-closed words come out zero-padded
    always_comb begin
        w_beat_in = '0;
        w_beat_in.data[8*(NUM_BYTES-1)-1:0] = acc_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (CW'(k) == cnt_q) w_beat_in.data[8*k +: 8] = data_i;
            w_beat_in.strb[k] = (CW'(k) <= cnt_q);
        end
        w_beat_in.last = w_last_in;
    end

    assign w_fifo_in    = {w_beat_in.data[8*NUM_BYTES-1:0], w_beat_in.strb[NUM_BYTES-1:0],
                           w_beat_in.last};
    assign w_unused_pad = (|w_beat_in) ^ w_fifo_out[0] ^ w_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                for (int k = 0; k < NUM_BYTES - 1; k++) begin
                    if (CW'(k) == cnt_q) acc_q[8*k +: 8] <= data_i;
                end
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    fifo_v2 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (DW),
        .DEPTH        (1)
    ) u_out_stage (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (clr_i),
        .testmode_i (testmode_i),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .data_i     (w_fifo_in),
        .push_i     (w_push),
        .data_o     (w_fifo_out),
        .pop_i      (ready_i)
    );

    assign data_o = valid_o ? w_fifo_out[DW-1 -: 8*NUM_BYTES] : '0;
    assign strb_o = valid_o ? w_fifo_out[NUM_BYTES:1] : '0;

endmodule
